// File: rtl/fsm_ctx_sched_pkg.sv
// rtl/fsm_ctx_sched_pkg.sv - shared types and helpers for the context-switched detector scheduler
//
// Purpose: engine state encoding, statistics counter width and the
//          two-state transition function shared by the scheduler files.
// Contents:
//   state_e     - engine state, ST_A = 0, ST_B = 1
//   STAT_W      - width of each per-channel toggle counter
//   next_state  - in = 0 toggles the state, in = 1 holds it
package fsm_ctx_sched_pkg;

  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } state_e;

  localparam int STAT_W = 16;

  function automatic state_e next_state(input state_e s, input logic in);
    return in ? s : state_e'(~s);
  endfunction

endpackage

// File: rtl/fsm_ctx_sched_rr_arbiter.sv
// rtl/fsm_ctx_sched_rr_arbiter.sv - combinational round-robin grant picker
//
// Purpose: picks the first asserted request starting at ptr and wrapping
//          modulo N. Holds no state; the pointer lives in the parent.
// Ports:
//   req     in  N  request vector
//   ptr     in  W  index where the search starts
//   gnt     out N  one-hot grant, all zero when no request is set
//   gnt_idx out W  index of the granted bit, 0 when no request is set
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                      = 1'b1;
        gnt[(int'(ptr) + k) % N]   = 1'b1;
        gnt_idx                    = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fsm_ctx_sched.sv
// rtl/fsm_ctx_sched.sv - time-shares one two-state detector among NUM_CH bit-stream channels
//
// Purpose: each channel keeps its engine state as a context bit. A
//          round-robin grant selects one channel per cycle, applies the
//          transition to its context and loads the result into a one-entry
//          response register with backpressure.
// Optional build macro: FSM_CTX_SCHED_STATS_EN adds per-channel saturating
//          counters of transfers with req_in = 0.
// Ports:
//   clk          in  1            clock
//   reset        in  1            synchronous, active-high reset
//   req_valid    in  NUM_CH       per-channel input bit valid
//   req_in       in  NUM_CH       per-channel input bit
//   req_ready    out NUM_CH       one-hot grant
//   ch_clr       in  NUM_CH       per-channel context clear to ST_B
//   rsp_valid    out 1            response valid
//   rsp_ready    in  1            consumer accepts the response
//   rsp_ch       out CH_W         channel of the response
//   rsp_out      out 1            new state of that channel
//   ctx_state    out NUM_CH       current context bit of every channel
//   stat_toggles out NUM_CH*16    (stats build only) toggle counters, ch0 in LSBs
module fsm_ctx_sched
  import fsm_ctx_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [NUM_CH-1:0] req_in,
  output logic [NUM_CH-1:0] req_ready,
  input  logic [NUM_CH-1:0] ch_clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CH_W-1:0]   rsp_ch,
  output logic              rsp_out,
  output logic [NUM_CH-1:0] ctx_state
`ifdef FSM_CTX_SCHED_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] stat_toggles
`endif
);

  logic [NUM_CH-1:0] ctx_q;
  logic [CH_W-1:0]   rr_ptr;
  logic              stall;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              xfer;
  logic              new_bit;

  // A held response blocks new work; a clear masks its channel so the clear
  // always wins over a same-cycle transfer. No grant while in reset.
  assign stall = rsp_valid & ~rsp_ready;
  assign elig  = req_valid & ~ch_clr & {NUM_CH{~stall & ~reset}};

  rr_arbiter #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign new_bit   = next_state(state_e'(ctx_q[gnt_idx]), req_in[gnt_idx]);
  assign ctx_state = ctx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_q     <= '1;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_ch    <= '0;
      rsp_out   <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) begin
          ctx_q[i] <= ST_B;
        end else if (gnt[i]) begin
          ctx_q[i] <= new_bit;
        end
      end
      // A transfer reloads the stage even when the old response is being
      // accepted this cycle, which keeps one transfer per cycle possible.
      if (xfer) begin
        rsp_valid <= 1'b1;
        rsp_ch    <= gnt_idx;
        rsp_out   <= new_bit;
        rr_ptr    <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FSM_CTX_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset || ch_clr[i]) begin
        stat_q[i] <= '0;
      end else if (gnt[i] && !req_in[i] && stat_q[i] != {STAT_W{1'b1}}) begin
        stat_q[i] <= stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_toggles = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stat_toggles[i*STAT_W +: STAT_W] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fsm_ctx_sched.sv
// tb/tb_fsm_ctx_sched.sv - directed table-driven bench for fsm_ctx_sched
module tb_fsm_ctx_sched;

  logic       clk;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_in;
  logic [3:0] req_ready;
  logic [3:0] ch_clr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_ch;
  logic       rsp_out;
  logic [3:0] ctx_state;
`ifdef FSM_CTX_SCHED_STATS_EN
  logic [63:0] stat_toggles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fsm_ctx_sched #(.NUM_CH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_in    (req_in),
    .req_ready (req_ready),
    .ch_clr    (ch_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ch    (rsp_ch),
    .rsp_out   (rsp_out),
    .ctx_state (ctx_state)
`ifdef FSM_CTX_SCHED_STATS_EN
    ,
    .stat_toggles (stat_toggles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] in;
    logic [3:0] clr;
    logic       rr;
    logic [3:0] gnt;
    logic       rv;
    logic [1:0] ch;
    logic       out;
    logic [3:0] ctx;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl [21];

  initial begin
    //              valid    in       clr      rr    gnt      rv    ch     out   ctx      ptr
    // single channel ch1: bits 0,0,1,0 then idle
    tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b1101, 2'd2};
    tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b1111, 2'd2};
    tbl[2]  = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b1111, 2'd2};
    tbl[3]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b1101, 2'd2};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1101, 2'd2};
    // fairness: all valid, hold bits, one grant per cycle in rotation
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b1101, 2'd3};
    tbl[6]  = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b1101, 2'd0};
    tbl[7]  = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b1101, 2'd1};
    tbl[8]  = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b1101, 2'd2};
    tbl[9]  = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b1101, 2'd3};
    // backpressure: 3 stalled cycles, then grant in the release cycle
    tbl[10] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b1101, 2'd3};
    tbl[11] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b1101, 2'd3};
    tbl[12] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b1101, 2'd3};
    tbl[13] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b1001, 2'd3};
    // clear collision: drive ctx0 to 0, then clear it while it requests
    tbl[14] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b1000, 2'd1};
    tbl[15] = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b1011, 2'd2};
    // wrap and skip: reach ptr 3, then only ch3 and ch0 valid
    tbl[16] = '{4'b0100, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b1011, 2'd3};
    tbl[17] = '{4'b1001, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b1011, 2'd0};
    tbl[18] = '{4'b1001, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b1011, 2'd1};
    // clear during stall applies, pending response untouched, then drain
    tbl[19] = '{4'b0010, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b1111, 2'd1};
    tbl[20] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1111, 2'd1};

    reset     = 1'b1;
    req_valid = 4'b1111;
    req_in    = 4'b0000;
    ch_clr    = 4'b0000;
    rsp_ready = 1'b1;

    @(posedge clk); #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_ch", 32'(rsp_ch), 32'h0);
    chk("reset_rsp_out", 32'(rsp_out), 32'h1);
    chk("reset_ctx", 32'(ctx_state), 32'hF);
    chk("reset_ptr", 32'(dut.rr_ptr), 32'h0);
`ifdef FSM_CTX_SCHED_STATS_EN
    chk("reset_stats", 32'(stat_toggles != 64'h0), 32'h0);
`endif

    reset = 1'b0;
    for (int v = 0; v < 21; v++) begin
      req_valid = tbl[v].valid;
      req_in    = tbl[v].in;
      ch_clr    = tbl[v].clr;
      rsp_ready = tbl[v].rr;
      #2;
      chk($sformatf("v%0d_gnt", v), 32'(req_ready), 32'(tbl[v].gnt));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(tbl[v].rv));
      if (tbl[v].rv) begin
        chk($sformatf("v%0d_rsp_ch", v), 32'(rsp_ch), 32'(tbl[v].ch));
        chk($sformatf("v%0d_rsp_out", v), 32'(rsp_out), 32'(tbl[v].out));
      end
      chk($sformatf("v%0d_ctx", v), 32'(ctx_state), 32'(tbl[v].ctx));
      chk($sformatf("v%0d_ptr", v), 32'(dut.rr_ptr), 32'(tbl[v].ptr));
    end

    // mid-operation reset with a response pending
    req_valid = 4'b0010;
    req_in    = 4'b0000;
    ch_clr    = 4'b0000;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_pre_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("mid_pre_ctx", 32'(ctx_state), 32'hD);
    reset     = 1'b1;
    req_valid = 4'b1111;
    #2;
    chk("mid_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rsp_out", 32'(rsp_out), 32'h1);
    chk("mid_ctx", 32'(ctx_state), 32'hF);
    chk("mid_ptr", 32'(dut.rr_ptr), 32'h0);
`ifdef FSM_CTX_SCHED_STATS_EN
    chk("mid_stats", 32'(stat_toggles != 64'h0), 32'h0);

    // ch0 toggles every cycle; counter counts up then saturates at FFFF
    req_valid = 4'b0001;
    req_in    = 4'b0000;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stat_ch0_3", 32'(stat_toggles[15:0]), 32'd3);
    repeat (65533) @(posedge clk);
    #1;
    chk("stat_ch0_max", 32'(stat_toggles[15:0]), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("stat_ch0_sat", 32'(stat_toggles[15:0]), 32'hFFFF);
    chk("stat_ch1_zero", 32'(stat_toggles[31:16]), 32'h0);
    req_valid = 4'b0000;
    ch_clr    = 4'b0001;
    @(posedge clk); #1;
    chk("stat_ch0_clr", 32'(stat_toggles[15:0]), 32'h0);
    ch_clr = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_ctx_sched.md
Name: fsm_ctx_sched

Overview:
- Time-shares one two-state detector engine among NUM_CH independent bit-stream channels.
- The engine has states A=0 and B=1. On in=0 the state toggles; on in=1 it holds. Output equals the new state.
- Each channel's state is stored as a context bit. A round-robin scheduler picks one channel per cycle and applies the transition to that channel's context.
- A one-entry registered response stage returns the result with backpressure. The block sits between the stream sources and the downstream result consumer.

Parameters:
- NUM_CH, 4, number of requester channels (2..16).
- CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel input bit valid.
- req_in  in  NUM_CH  per-channel input bit.
- req_ready  out  NUM_CH  one-hot grant; a transfer happens when req_valid[i]&req_ready[i].
- ch_clr  in  NUM_CH  per-channel context clear to B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_ch  out  CH_W  channel index of the response.
- rsp_out  out  1  new state of that channel.
- ctx_state  out  NUM_CH  current context bit of every channel.

Behaviour:
- Reset: all ctx bits = B (1); rr_ptr = 0; rsp_valid = 0; rsp_ch = 0; rsp_out = 1; req_ready = 0 during the reset cycle.
- Stall: stall = rsp_valid & ~rsp_ready. While stall is high, req_ready = 0 and no context changes except clears.
- Eligibility: elig[i] = req_valid[i] & ~ch_clr[i] & ~stall.
- Grant:
  - Combinational, one-hot, first eligible channel searching rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - req_ready = grant.
  - No eligible channel → grant = 0.
- On a transfer to channel g, at the clk edge:
  - ctx[g] ← (req_in[g] ? ctx[g] : ~ctx[g]).
  - rsp_valid ← 1, rsp_ch ← g, rsp_out ← new ctx[g].
  - rr_ptr ← (g+1) mod NUM_CH.
- Latency: one cycle from transfer to rsp_valid.
- Response stage:
  - Cleared when rsp_valid & rsp_ready and there is no new transfer.
  - Accept and new transfer in the same cycle → reloads, giving full throughput of one transfer per cycle.
  - With rsp_valid & ~rsp_ready, rsp_ch and rsp_out hold stable.
- ch_clr[i]:
  - ctx[i] ← B at the edge.
  - Channel i is masked from the grant that cycle, so clear always wins over a transfer.
  - Clear during a stall still applies.
  - A pending response already in the stage is not altered.
- rr_ptr does not advance when there is no grant.
- Wrap: grant at NUM_CH-1 → rr_ptr = 0.
- Reset mid-operation discards any pending response; nothing is replayed.

Optional Feature:
- Macro: FSM_CTX_SCHED_STATS_EN.
- Defined:
  - Adds output port stat_toggles, NUM_CH*16 bits.
  - Holds per-channel 16-bit saturating counters, incremented on each transfer with req_in=0.
  - Counters stick at 16'hFFFF.
  - Cleared by reset or ch_clr[i].
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fsm_ctx_sched_pkg:
  - typedef state_e {ST_A=1'b0, ST_B=1'b1}.
  - localparam STAT_W=16.
  - function next_state(state_e s, logic in).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Output: one-hot gnt[N] and its index.
  - Purely combinational; rr_ptr is held in the parent.

Test Plan:
- Reset, then a single channel:
  - ch1 sends bits 0,0,1,0 with rsp_ready=1.
  - Required: rsp_out sequence 0,1,1,0 with rsp_ch=1 each, one cycle after each transfer; ctx_state[1] ends 0.
- Fairness, NUM_CH=4:
  - All req_valid=1 continuously.
  - Required: grants ch0,1,2,3,0,1,... with exactly one transfer per cycle.
- Backpressure:
  - rsp_ready=0 for 3 cycles while ch2 is valid.
  - Required: req_ready=0, the response is held stable, ctx unchanged.
  - On rsp_ready=1: the next grant is issued in the same cycle.
- Clear collision:
  - ch0 has req_valid=1, req_in=0, ctx=0, and ch_clr[0]=1 in the same cycle.
  - Required: no grant to ch0; ctx[0]=1 afterwards; ch1 is granted if valid.
- Wrap and skip:
  - Only ch3 and ch0 valid, rr_ptr=3.
  - Required: ch3 granted, then ch0; rr_ptr goes 0 then 1.
- Mid-operation reset:
  - Reset asserted while rsp_valid=1.
  - Required: next cycle rsp_valid=0, all ctx=1, rr_ptr=0.
  - With FSM_CTX_SCHED_STATS_EN defined, also check that counters are 0 and that one saturates at FFFF.
